// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and memory-wait stall FSM.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        LoadE,
  input  logic        PCSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        MemReqM,
  input  logic        MemReady,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemTimeout,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {RUN, MEMWAIT, TIMEOUT} state_t;

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       lw_stall;
  logic       mem_stall;

  logic [1:0][4:0] rs_e;
  logic [1:0][1:0] fwd;

  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;

  // Memory-stage result is younger than writeback, so it wins.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] = (RegWriteM && (RdM != 5'd0) && (RdM == rs_e[gi])) ? 2'b10 :
                       (RegWriteW && (RdW != 5'd0) && (RdW == rs_e[gi])) ? 2'b01 :
                                                                           2'b00;
    end
  endgenerate

  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_stall     = 1'b0;
    unique case (state_reg)
      RUN: begin
        if (MemReqM && !MemReady) begin
          mem_stall     = 1'b1;
          state_next    = MEMWAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MEMWAIT: begin
        if (MemReady) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
        end else begin
          mem_stall     = 1'b1;
          wait_cnt_next = wait_cnt_reg + 8'd1;
          // The RUN cycle that opened the wait counts as the first stalled cycle.
          if (wait_cnt_reg == 8'(MEM_TIMEOUT - 1))
            state_next = TIMEOUT;
        end
      end
      TIMEOUT: mem_stall = 1'b1;
      default: state_next = RUN;
    endcase
  end

  assign MemTimeout = (state_reg == TIMEOUT);

  // A flush beats a load-use stall: IF_ID only honours clear while enabled.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall && !PCSrcE;
      StallD = lw_stall && !PCSrcE;
      FlushD = PCSrcE;
      FlushE = lw_stall || PCSrcE;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_reg, flush_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_reg <= 32'd0;
      flush_count_reg  <= 32'd0;
    end else begin
      if (StallF && (stall_cycles_reg != 32'hFFFF_FFFF))
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (FlushD && (flush_count_reg != 32'hFFFF_FFFF))
        flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_reg;
  assign FlushCount  = flush_count_reg;
`else
  assign StallCycles = 32'd0;
  assign FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MEM_TIMEOUT=4); counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        LoadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReady;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [31:0] StallCycles, FlushCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RdM(RdM), .RdW(RdW),
    .MemReqM(MemReqM), .MemReady(MemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    LoadE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReady = 0;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stalls(input string tag, input logic [6:0] exp);
    check(tag, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, exp});
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    check("reset_stalls", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 32'd0);
    check("reset_timeout", {31'd0, MemTimeout}, 32'd0);
    check("reset_stallcycles", StallCycles, 32'd0);
    check("reset_flushcount", FlushCount, 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // Forwarding
    next_cycle();
    RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
    @(negedge clk); check("fwdA_mem_priority", {30'd0, ForwardAE}, 32'h2);
    RegWriteM = 0;
    #1; check("fwdA_wb", {30'd0, ForwardAE}, 32'h1);
    idle(); RegWriteM = 1; RegWriteW = 1;
    #1; check("fwdA_x0", {30'd0, ForwardAE}, 32'h0);
    idle(); Rs1E = 3; RdM = 3; RegWriteM = 1; Rs2E = 9; RdW = 9; RegWriteW = 1;
    #1; check("fwdA_mem", {30'd0, ForwardAE}, 32'h2);
    check("fwdB_wb", {30'd0, ForwardBE}, 32'h1);
    RegWriteW = 0;
    #1; check("fwdB_nowrite", {30'd0, ForwardBE}, 32'h0);
    RdM = 9; RegWriteM = 1;
    #1; check("fwdB_mem", {30'd0, ForwardBE}, 32'h2);

    // Load-use stall, bits: StallF StallD StallE StallM FlushD FlushE FlushW
    next_cycle(); idle(); LoadE = 1; RdE = 7; Rs2D = 7;
    @(negedge clk); check_stalls("loaduse", 7'b1100010);
    next_cycle(); idle();
    @(negedge clk); check_stalls("loaduse_release", 7'b0000000);
    next_cycle(); LoadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
    @(negedge clk); check_stalls("loaduse_branch", 7'b0000110);
    next_cycle(); idle(); LoadE = 1; RdE = 0; Rs1D = 0;
    @(negedge clk); check_stalls("loaduse_x0", 7'b0000000);
    next_cycle(); idle(); LoadE = 1; RdE = 12; Rs1D = 12;
    @(negedge clk); check_stalls("loaduse_rs1", 7'b1100010);

    // Memory wait: three stalled cycles then release
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); MemReqM = 1; PCSrcE = 1;
      @(negedge clk); check_stalls($sformatf("memwait_%0d", i), 7'b1111001);
    end
    next_cycle(); idle(); MemReqM = 1; MemReady = 1;
    @(negedge clk); check_stalls("memwait_release", 7'b0000000);
    check("memwait_no_timeout", {31'd0, MemTimeout}, 32'd0);
    next_cycle(); idle(); PCSrcE = 1;
    @(negedge clk); check_stalls("after_wait_branch", 7'b0000110);

    // Timeout with MEM_TIMEOUT=4
    for (int i = 0; i < 4; i++) begin
      next_cycle(); idle(); MemReqM = 1;
      @(negedge clk); check_stalls($sformatf("to_stall_%0d", i), 7'b1111001);
      check($sformatf("to_flag_%0d", i), {31'd0, MemTimeout}, 32'd0);
    end
    next_cycle(); idle(); MemReady = 1;
    @(negedge clk); check("timeout_flag", {31'd0, MemTimeout}, 32'd1);
    check_stalls("timeout_stall", 7'b1111001);
    next_cycle();
    @(negedge clk); check("timeout_sticky", {31'd0, MemTimeout}, 32'd1);
    reset_n = 1'b0;
    #1; check("timeout_reset_flag", {31'd0, MemTimeout}, 32'd0);
    check_stalls("timeout_reset_stall", 7'b0000000);
    next_cycle(); reset_n = 1'b1; idle();
    @(negedge clk); check_stalls("post_reset_run", 7'b0000000);

    // Performance counters: two load-use stalls and one branch
    next_cycle(); reset_n = 1'b0;
    next_cycle(); reset_n = 1'b1;
    next_cycle(); LoadE = 1; RdE = 4; Rs1D = 4;
    next_cycle(); idle();
    next_cycle(); LoadE = 1; RdE = 6; Rs2D = 6;
    next_cycle(); idle();
    next_cycle(); PCSrcE = 1;
    next_cycle(); idle();
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stallcycles", StallCycles, 32'd2);
    check("perf_flushcount", FlushCount, 32'd1);
`else
    check("perf_stallcycles", StallCycles, 32'd0);
    check("perf_flushcount", FlushCount, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
